// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and the BCD validity helper for the
// BCD-to-binary converter.
package bcd_pkg;

  localparam int DIGITS = 5;
  localparam int BIN_W  = 16;
  localparam int ACC_W  = 17;
  localparam int ITER   = 17;
  localparam int BCD_W  = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic bcd_digits_ok(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Reverse double-dabble digit correction: a digit that reached 8 or more
// after the right shift carried a half-ten from above and loses 3.
module bcd_digit_corr (
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  always_comb begin
    d_out = d_in;
    if (d_in >= 4'd8) d_out = d_in - 4'd3;
  end

endmodule

// File: rtl/bcd2bin_16.sv
// Five-digit BCD to 16-bit binary converter, one bit per cycle (17 cycles).
// Build option BCD2BIN_SAT_EN: saturate bin_out to FFFF on overflow instead of wrapping.
module bcd2bin_16
  import bcd_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        start,
  input  logic [19:0] bcd_in,
  output logic [15:0] bin_out,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        err
);

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  logic [BCD_W+ACC_W-1:0] sh;
  logic [BCD_W-1:0]       bcd_sh, bcd_corr;
  logic [ACC_W-1:0]       acc_sh;

  assign sh     = {bcd_q, acc_q} >> 1;
  assign bcd_sh = sh[BCD_W+ACC_W-1:ACC_W];
  assign acc_sh = sh[ACC_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .d_in  (bcd_sh[4*g +: 4]),
      .d_out (bcd_corr[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (bcd_digits_ok(bcd_in)) begin
            bcd_d   = bcd_in;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = CONV;
          end else begin
            // Invalid digit: report immediately, no conversion cycles spent.
            bin_d   = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      CONV: begin
        bcd_d = bcd_corr;
        acc_d = acc_sh;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) begin
          ovf_d   = acc_sh[ACC_W-1];
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
`ifdef BCD2BIN_SAT_EN
          bin_d   = acc_sh[ACC_W-1] ? '1 : acc_sh[BIN_W-1:0];
`else
          bin_d   = acc_sh[BIN_W-1:0];
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CONV);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign bin_out = bin_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd2bin_16.sv
// Randomised self-checking bench for bcd2bin_16 against a decimal-arithmetic model.
module tb_bcd2bin_16;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic        start;
  logic [19:0] bcd_in;
  logic [15:0] bin_out;
  logic        busy, done, ovf, err;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] prev_bin;
  logic        prev_ovf, prev_err;

  always #10 CLOCK_50 = ~CLOCK_50;

  bcd2bin_16 dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .start    (start),
    .bcd_in   (bcd_in),
    .bin_out  (bin_out),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .err      (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal model: weigh each digit by its power of ten.
  task automatic model(input logic [19:0] b, output logic [15:0] e_bin, output logic e_ovf,
                       output logic e_err, output int e_lat, output int e_busy);
    int unsigned v, mult, d;
    bit ok;
    v = 0; mult = 1; ok = 1;
    for (int i = 0; i < 5; i++) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) ok = 0;
      v += d * mult;
      mult *= 10;
    end
    if (!ok) begin
      e_bin = 16'h0; e_ovf = 1'b0; e_err = 1'b1; e_lat = 1; e_busy = 0;
    end else begin
      e_ovf = (v > 65535);
      e_err = 1'b0; e_lat = 18; e_busy = 17;
`ifdef BCD2BIN_SAT_EN
      e_bin = e_ovf ? 16'hFFFF : v[15:0];
`else
      e_bin = v[15:0];
`endif
    end
  endtask

  task automatic do_conv(input logic [19:0] b, input bit poke);
    logic [15:0] e_bin;
    logic        e_ovf, e_err;
    int          e_lat, e_busy, k, busy_cnt;
    bit          seen;
    model(b, e_bin, e_ovf, e_err, e_lat, e_busy);
    start = 1'b1; bcd_in = b;
    @(posedge CLOCK_50);
    #1 start = 1'b0; bcd_in = $urandom;
    seen = 0; busy_cnt = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge CLOCK_50);
      if (poke && k == 5) begin start = 1'b1; bcd_in = 20'h98765; end
      if (poke && k == 6) start = 1'b0;
      if (k == 9 && e_lat == 18) begin
        check_eq("hold_bin", {16'h0, bin_out}, {16'h0, prev_bin});
        check_eq("hold_flags", {30'h0, ovf, err}, {30'h0, prev_ovf, prev_err});
      end
      if (done) begin seen = 1; break; end
      if (busy) busy_cnt++;
    end
    if (!seen) begin
      check_eq("done_timeout", 0, 1);
      start = 1'b0;
      return;
    end
    check_eq("latency", k, e_lat);
    check_eq("busy_cycles", busy_cnt, e_busy);
    check_eq("bin_out", {16'h0, bin_out}, {16'h0, e_bin});
    check_eq("ovf", {31'h0, ovf}, {31'h0, e_ovf});
    check_eq("err", {31'h0, err}, {31'h0, e_err});
    @(negedge CLOCK_50);
    check_eq("done_pulse", {31'h0, done}, 32'h0);
    check_eq("bin_after", {16'h0, bin_out}, {16'h0, e_bin});
    prev_bin = e_bin; prev_ovf = e_ovf; prev_err = e_err;
  endtask

  initial begin
    logic [19:0] r;
    bit saw;
    RESET_N = 1'b0; start = 1'b0; bcd_in = 20'h0;
    prev_bin = 16'h0; prev_ovf = 1'b0; prev_err = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_eq("reset_out", {11'h0, bin_out, busy, done, ovf, err, 1'b0}, 32'h0);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);

    do_conv(20'h12345, 0);
    do_conv(20'h65535, 0);
    do_conv(20'h65536, 0);
    do_conv(20'h1A000, 0);
    do_conv(20'h99999, 0);
    do_conv(20'h00000, 0);
    do_conv(20'h54321, 1);

    // Abort a conversion at iteration 10 with reset.
    start = 1'b1; bcd_in = 20'h43210;
    @(posedge CLOCK_50);
    #1 start = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    RESET_N = 1'b0;
    #1 check_eq("abort_out", {11'h0, bin_out, busy, done, ovf, err, 1'b0}, 32'h0);
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    saw = 0;
    repeat (25) begin
      @(negedge CLOCK_50);
      if (done) saw = 1;
    end
    check_eq("no_done_after_abort", {31'h0, saw}, 32'h0);
    prev_bin = 16'h0; prev_ovf = 1'b0; prev_err = 1'b0;
    do_conv(20'h00000, 0);

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) r = 20'($urandom);
      else
        for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
      do_conv(r, ($urandom_range(0, 4) == 0) && n > 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
